fir_channel_scheduler: RTL
==========================

// Module: fir_channel_scheduler
// PURPOSE
//  Time-shares one combinational 6-tap FIR core (fir_accurate, or an approximate variant) among NCH sample channels.
//  Keeps one 6-deep delay line per channel and grants one channel per cycle, round-robin.
//  Presents the selected channel's taps to the core, then registers the core result with a channel tag.
//  Sits between the per-channel sample sources and the shared FIR datapath; the core is external so variants swap freely.
// PARAMETERS
//  NCH   4   number of input channels (>=2)
//  DW    32  sample/result width, signed two's complement
//  NTAP  6   delay-line depth; fixed to the core's six inputs
// PORTS
//  clk        in   1        single clock, rising edge
//  rst_n      in   1        asynchronous, active-low reset
//  clear      in   1        synchronous flush of all channel state
//  s_valid    in   NCH      per-channel sample valid
//  s_data     in   NCH*DW   per-channel samples, ch k at [k*DW +: DW]
//  s_ready    out  NCH      one-hot grant/accept
//  core_in    out  NTAP*DW  taps to core: [0 +: DW]=in_1_0 (newest) .. [5*DW +: DW]=in_6_0 (oldest)
//  core_out   in   DW       combinational core result (out_11)
//  m_valid    out  1        result valid
//  m_data     out  DW       registered core result
//  m_chan     out  $clog2(NCH)  channel of m_data
//  m_warm     out  1        1 once the channel has >= NTAP accepted samples
//  m_ready    in   1        downstream accept
//  busy       out  1        p_valid | m_valid
// BEHAVIOUR
//  Reset (rst_n=0, immediate): all taps 0, warm counters 0, rr pointer 0.
//   Also p_valid=0, m_valid=0, m_data=0, m_chan=0, m_warm=0, s_ready=0.
//  stall = m_valid & ~m_ready. Output slot free = ~m_valid | m_ready.
//  Grant: s_ready[k]=1 for the first k with s_valid[k]=1, searching from rr_ptr upward and wrapping.
//   Gated by ~clear & ~(p_valid & stall). At most one bit set.
//   s_ready depends combinationally on s_valid; sources must not make s_valid depend on s_ready.
//  Accept edge (s_valid[k]&s_ready[k]): shift ch k only.
//   tap[5]<=tap[4] .. tap[1]<=tap[0], tap[0]<=s_data[k].
//   warm_cnt[k] saturates at 6 (3 bits). p_valid<=1, p_chan<=k, rr_ptr<=(k+1) mod NCH.
//  Issue cycle (p_valid=1): core_in = taps of p_chan (post-shift). Other channels' taps are unaffected.
//   At the edge, if the slot is free: m_data<=core_out, m_chan<=p_chan, m_warm<=(warm_cnt[p_chan]==6), m_valid<=1.
//   If nothing new enters p, p_valid<=0 at that edge.
//   Otherwise p holds and core_in stays stable.
//  m_valid clears on m_ready unless it is reloaded in the same edge.
//  Latency: accept at edge E -> m_valid at edge E+1 (no stall). Throughput 1 sample/cycle with m_ready=1.
//  Simultaneous events:
//   - An accept into ch k while p_chan==k is draining is legal; the core reads the pre-edge taps.
//   - No accept while p is stalled, so no overwrite or loss.
//  clear=1 (sync, beats accept): taps, warm counters, p_valid, m_valid, rr_ptr -> 0 next edge. s_ready=0 that cycle.
//  Mid-operation reset drops any pending sample/result; no partial update survives.
//  When p_valid=0, core_in = 0.
//  No arithmetic in this block; data passes through at DW bits, signed, no truncation.
// STRUCTURE
//  fir_sched_pkg: DW, NTAP, NCH default, typedef chan_t = logic [$clog2(NCH)-1:0].
//   Also typedef sample_t = logic signed [DW-1:0], and WARM_MAX=6.
//  Sub-module fir_rr_arbiter: req[NCH], ptr, en -> one-hot gnt, gnt_idx. Combinational; ptr register stays in parent.
//  Parent holds the delay lines, warm counters, p stage, output register and core_in mux.
// TESTING
//  1 ch0 only, samples 1..6, m_ready=1 -> 6th result: core_in newest..oldest = 6,5,4,3,2,1.
//    m_chan=0; m_warm 0 for results 1-5, 1 for 6; each m_valid one edge after its accept.
//  2 All 4 ch valid every cycle, m_ready=1 -> s_ready 0001,0010,0100,1000,0001...
//    m_chan sequence 0,1,2,3,0; one result per cycle.
//  3 As 2 but m_ready=0 for 5 cycles -> m_data/m_chan stable; s_ready=0 after p fills.
//    After release, results resume in order, none lost or duplicated (scoreboard vs. software FIR).
//  4 Interleave ch0=10, ch1=-1, ch0=20 -> ch1 core_in = -1,0,0,0,0,0; ch0 core_in = 20,10,0,0,0,0.
//  5 clear asserted with p_valid=1 and m_valid=1 -> next cycle m_valid=0, busy=0.
//    Then ch2 sample 7 gives core_in 7,0,0,0,0,0 and m_warm=0; first grant after clear goes to ch0 if it requests.
//  6 rst_n pulsed low between edges mid-stream -> m_valid, s_ready, core_in go to 0 without a clock edge.
//    Operation restarts cleanly on release.

Source files
------------

// File: rtl/fir_sched_pkg.sv
// Shared constants and types for the multi-channel FIR scheduler.
// NCH_DEF/DW_DEF are defaults only; the scheduler exposes NCH/DW as parameters.
package fir_sched_pkg;
    localparam int NCH_DEF  = 4;
    localparam int DW_DEF   = 32;
    localparam int NTAP     = 6;
    localparam int WARM_MAX = 6;
    localparam int CHW_DEF  = $clog2(NCH_DEF);

    typedef logic [CHW_DEF-1:0]       chan_t;
    typedef logic signed [DW_DEF-1:0] sample_t;
endpackage

// File: rtl/fir_channel_scheduler_if.sv
// Sample-source and result-sink handshakes of the FIR channel scheduler.
// master = scheduler side, slave = sources/sink side.
interface fir_channel_scheduler_if #(
    parameter int NCH = fir_sched_pkg::NCH_DEF,
    parameter int DW  = fir_sched_pkg::DW_DEF
) ();
    logic [NCH-1:0]          s_valid;
    logic [NCH-1:0][DW-1:0]  s_data;
    logic [NCH-1:0]          s_ready;
    logic                    m_valid;
    logic [DW-1:0]           m_data;
    logic [$clog2(NCH)-1:0]  m_chan;
    logic                    m_warm;
    logic                    m_ready;

    modport master (
        input  s_valid, s_data, m_ready,
        output s_ready, m_valid, m_data, m_chan, m_warm
    );

    modport slave (
        output s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_data, m_chan, m_warm
    );
endinterface

// File: rtl/fir_rr_arbiter.sv
// Combinational round-robin picker: first requester at or above ptr, wrapping.
// The pointer register lives in the parent.
module fir_rr_arbiter
    import fir_sched_pkg::*;
#(
    parameter int NCH = NCH_DEF
) (
    input  logic [NCH-1:0]         req,
    input  logic [$clog2(NCH)-1:0] ptr,
    input  logic                   en,
    output logic [NCH-1:0]         gnt,
    output logic [$clog2(NCH)-1:0] gnt_idx
);
    localparam int CW = $clog2(NCH);

    logic          found;
    logic [CW-1:0] sel;
    int            idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        sel     = '0;
        for (int i = 0; i < NCH; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NCH) idx = idx - NCH;
            sel = CW'(idx);
            if (en && !found && req[sel]) begin
                found      = 1'b1;
                gnt[sel]   = 1'b1;
                gnt_idx    = sel;
            end
        end
    end
endmodule

// File: rtl/fir_channel_scheduler.sv
// Time-shares one external combinational 6-tap FIR core among NCH channels:
// per-channel delay lines, round-robin grant, one issue stage and a registered result.
module fir_channel_scheduler
    import fir_sched_pkg::*;
#(
    parameter int NCH = NCH_DEF,
    parameter int DW  = DW_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    fir_channel_scheduler_if.master bus,
    output logic [NTAP-1:0][DW-1:0] core_in,
    input  logic [DW-1:0]           core_out,
    output logic                    busy
);
    localparam int CW = $clog2(NCH);
    localparam int WW = $clog2(WARM_MAX + 1);

    logic [NCH-1:0][NTAP-1:0][DW-1:0] taps, taps_nxt;
    logic [NCH-1:0][WW-1:0]           warm_cnt, warm_nxt;
    logic [CW-1:0]                    rr_ptr, ptr_nxt, p_chan, gnt_idx;
    logic [NCH-1:0]                   gnt;
    logic                             p_valid;
    logic                             stall, slot_free, arb_en, accept, issue;

    assign stall     = bus.m_valid & ~bus.m_ready;
    assign slot_free = ~bus.m_valid | bus.m_ready;
    // rst_n in the enable keeps s_ready low during reset even though it is combinational.
    assign arb_en    = rst_n & ~clear & ~(p_valid & stall);
    assign accept    = |gnt;
    assign issue     = p_valid & slot_free;
    assign ptr_nxt   = (gnt_idx == CW'(NCH - 1)) ? '0 : gnt_idx + 1'b1;

    fir_rr_arbiter #(.NCH(NCH)) u_arb (
        .req     (bus.s_valid),
        .ptr     (rr_ptr),
        .en      (arb_en),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign bus.s_ready = gnt;
    assign core_in     = p_valid ? taps[p_chan] : '0;
    assign busy        = p_valid | bus.m_valid;

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        assign taps_nxt[k] = gnt[k] ? {taps[k][NTAP-2:0], bus.s_data[k]} : taps[k];
        assign warm_nxt[k] = (gnt[k] && warm_cnt[k] != WW'(WARM_MAX)) ? warm_cnt[k] + 1'b1
                                                                       : warm_cnt[k];
    end

    // The core sees pre-edge taps, so an accept into the draining channel is safe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            taps        <= '0;
            warm_cnt    <= '0;
            rr_ptr      <= '0;
            p_valid     <= 1'b0;
            p_chan      <= '0;
            bus.m_valid <= 1'b0;
            bus.m_data  <= '0;
            bus.m_chan  <= '0;
            bus.m_warm  <= 1'b0;
        end else if (clear) begin
            taps        <= '0;
            warm_cnt    <= '0;
            rr_ptr      <= '0;
            p_valid     <= 1'b0;
            p_chan      <= '0;
            bus.m_valid <= 1'b0;
        end else begin
            taps     <= taps_nxt;
            warm_cnt <= warm_nxt;
            if (accept) begin
                p_valid <= 1'b1;
                p_chan  <= gnt_idx;
                rr_ptr  <= ptr_nxt;
            end else if (issue) begin
                p_valid <= 1'b0;
            end
            if (issue) begin
                bus.m_valid <= 1'b1;
                bus.m_data  <= core_out;
                bus.m_chan  <= p_chan;
                bus.m_warm  <= (warm_cnt[p_chan] == WW'(WARM_MAX));
            end else if (bus.m_ready) begin
                bus.m_valid <= 1'b0;
            end
        end
    end
endmodule
